// File: rtl/rv64g_l1_pkg.sv
// Shared L1 definitions: scheduler state encoding, bank count and bank-select helpers.
package rv64g_l1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FORCE = 2'd2
    } sched_state_t;

    localparam int L1_NUM_BANKS = 8;
    localparam int L1_BANK_W    = 3;

    // Banks are word-interleaved: the low word-offset bits pick the bank.
    function automatic logic [L1_BANK_W-1:0] bank_of(input logic [2:0] word);
        bank_of = word[L1_BANK_W-1:0];
    endfunction

    function automatic logic [L1_NUM_BANKS-1:0] bank_onehot(input logic [L1_BANK_W-1:0] bank);
        bank_onehot       = '0;
        bank_onehot[bank] = 1'b1;
    endfunction

endpackage

// File: rtl/rv64g_l1_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module rv64g_l1_sat_counter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (clr_i) begin
            count_o <= '0;
        end else if (inc_i && (count_o != '1)) begin
            count_o <= count_o + W'(1);
        end
    end

endmodule

// File: rtl/rv64g_l1_vec_bank_sched.sv
// Vector-lane request scheduler: holds one vector access, steers it to its bank,
// and forces a scalar hold on that bank after repeated stalls.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | holding register empty, ready for a new request
// PEND  | request presented to bank_q, counting consecutive stalls
// FORCE | request presented, scalar hold raised on bank_q
module rv64g_l1_vec_bank_sched
    import rv64g_l1_pkg::*;
#(
    parameter int NUM_BANKS    = 8,
    parameter int INDEX_W      = 5,
    parameter int ID_W         = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int STAT_W       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 vreq_valid_i,
    output logic                 vreq_ready_o,
    input  logic                 vreq_we_i,
    input  logic [INDEX_W-1:0]   vreq_index_i,
    input  logic [2:0]           vreq_word_i,
    input  logic [2:0]           vreq_way_i,
    input  logic [7:0]           vreq_be_i,
    input  logic [63:0]          vreq_wdata_i,
    input  logic [ID_W-1:0]      vreq_id_i,
    output logic [NUM_BANKS-1:0] vec_req_o,
    output logic                 vec_we_o,
    output logic [INDEX_W-1:0]   vec_index_o,
    output logic [2:0]           vec_word_o,
    output logic [2:0]           vec_way_o,
    output logic [7:0]           vec_be_o,
    output logic [63:0]          vec_wdata_o,
    input  logic [NUM_BANKS-1:0] vec_stall_i,
    output logic [NUM_BANKS-1:0] scalar_hold_o,
    output logic                 issue_valid_o,
    output logic [ID_W-1:0]      issue_id_o,
    output logic [2:0]           issue_bank_o,
    output logic [STAT_W-1:0]    force_events_o
);

    localparam logic [2:0] LIMIT_C = 3'(STARVE_LIMIT);

    sched_state_t      state;
    logic [2:0]        bank_q;
    logic [ID_W-1:0]   id_q;
    logic [2:0]        stall_cnt;
    logic              busy;
    logic              grant;
    logic              handshake;
    logic              stall_inc;
    logic              reach_limit;

    assign busy         = (state != ST_IDLE);
    assign grant        = busy && !vec_stall_i[bank_q];
    assign vreq_ready_o = !rst_i && ((state == ST_IDLE) || grant);
    assign handshake    = vreq_valid_i && vreq_ready_o;
    assign stall_inc    = (state == ST_PEND) && vec_stall_i[bank_q];
    assign reach_limit  = stall_inc && ((stall_cnt + 3'd1) == LIMIT_C);

    // Both decoded from registered state only, so no input reaches the hold path.
    assign vec_req_o     = busy ? bank_onehot(bank_q) : '0;
    assign scalar_hold_o = (state == ST_FORCE) ? bank_onehot(bank_q) : '0;
    assign vec_word_o    = bank_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            bank_q        <= '0;
            id_q          <= '0;
            vec_we_o      <= 1'b0;
            vec_index_o   <= '0;
            vec_way_o     <= '0;
            vec_be_o      <= '0;
            vec_wdata_o   <= '0;
            issue_valid_o <= 1'b0;
            issue_id_o    <= '0;
            issue_bank_o  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) state <= ST_PEND;
                end
                ST_PEND, ST_FORCE: begin
                    if (grant)            state <= handshake ? ST_PEND : ST_IDLE;
                    else if (reach_limit) state <= ST_FORCE;
                end
                default: state <= ST_IDLE;
            endcase

            if (handshake) begin
                bank_q      <= bank_of(vreq_word_i);
                id_q        <= vreq_id_i;
                vec_we_o    <= vreq_we_i;
                vec_index_o <= vreq_index_i;
                vec_way_o   <= vreq_way_i;
                vec_be_o    <= vreq_be_i;
                vec_wdata_o <= vreq_wdata_i;
            end

            issue_valid_o <= grant;
            if (grant) begin
                issue_id_o   <= id_q;
                issue_bank_o <= bank_q;
            end
        end
    end

    rv64g_l1_sat_counter #(.W(3)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (grant),
        .inc_i   (stall_inc),
        .count_o (stall_cnt)
    );

    rv64g_l1_sat_counter #(.W(STAT_W)) u_force_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (1'b0),
        .inc_i   (reach_limit),
        .count_o (force_events_o)
    );

endmodule

// File: tb/tb_rv64g_l1_vec_bank_sched.sv
// Directed bench for the vector bank scheduler: per-cycle vector table plus
// hand-written starvation, broadcast and reset sequences.
module tb_rv64g_l1_vec_bank_sched;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        vreq_valid_i;
    logic        vreq_ready_o;
    logic        vreq_we_i;
    logic [4:0]  vreq_index_i;
    logic [2:0]  vreq_word_i;
    logic [2:0]  vreq_way_i;
    logic [7:0]  vreq_be_i;
    logic [63:0] vreq_wdata_i;
    logic [3:0]  vreq_id_i;
    logic [7:0]  vec_req_o;
    logic        vec_we_o;
    logic [4:0]  vec_index_o;
    logic [2:0]  vec_word_o;
    logic [2:0]  vec_way_o;
    logic [7:0]  vec_be_o;
    logic [63:0] vec_wdata_o;
    logic [7:0]  vec_stall_i;
    logic [7:0]  scalar_hold_o;
    logic        issue_valid_o;
    logic [3:0]  issue_id_o;
    logic [2:0]  issue_bank_o;
    logic [15:0] force_events_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    rv64g_l1_vec_bank_sched dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .vreq_valid_i   (vreq_valid_i),
        .vreq_ready_o   (vreq_ready_o),
        .vreq_we_i      (vreq_we_i),
        .vreq_index_i   (vreq_index_i),
        .vreq_word_i    (vreq_word_i),
        .vreq_way_i     (vreq_way_i),
        .vreq_be_i      (vreq_be_i),
        .vreq_wdata_i   (vreq_wdata_i),
        .vreq_id_i      (vreq_id_i),
        .vec_req_o      (vec_req_o),
        .vec_we_o       (vec_we_o),
        .vec_index_o    (vec_index_o),
        .vec_word_o     (vec_word_o),
        .vec_way_o      (vec_way_o),
        .vec_be_o       (vec_be_o),
        .vec_wdata_o    (vec_wdata_o),
        .vec_stall_i    (vec_stall_i),
        .scalar_hold_o  (scalar_hold_o),
        .issue_valid_o  (issue_valid_o),
        .issue_id_o     (issue_id_o),
        .issue_bank_o   (issue_bank_o),
        .force_events_o (force_events_o)
    );

    typedef struct {
        logic       valid;
        logic [2:0] word;
        logic [3:0] id;
        logic [7:0] stall;
        logic       rdy;
        logic [7:0] req;
        logic [7:0] hold;
        logic       iv;
        logic [3:0] iid;
        logic [2:0] ibank;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(logic v, logic [2:0] w, logic [3:0] id, logic [7:0] st,
                                logic rdy, logic [7:0] req, logic [7:0] hold,
                                logic iv, logic [3:0] iid, logic [2:0] ib);
        vec_t r;
        r.valid = v;  r.word = w;   r.id = id;     r.stall = st;
        r.rdy = rdy;  r.req = req;  r.hold = hold;
        r.iv = iv;    r.iid = iid;  r.ibank = ib;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] w, input logic [3:0] id, input logic [7:0] st);
        vreq_valid_i = v;
        vreq_word_i  = w;
        vreq_id_i    = id;
        vec_stall_i  = st;
    endtask

    initial begin
        rst_i        = 1'b1;
        vreq_we_i    = 1'b0;
        vreq_index_i = '0;
        vreq_way_i   = '0;
        vreq_be_i    = '0;
        vreq_wdata_i = '0;
        drive(1'b1, 3'd0, 4'd0, 8'h00);

        // valid, word, id, stall | ready, vec_req, hold, issue_v, issue_id, issue_bank
        tbl[0]  = mk(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 0);
        tbl[1]  = mk(1, 3, 5, 8'h00, 1, 8'h00, 8'h00, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 8'h00, 1, 8'h08, 8'h00, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 1, 5, 3);
        tbl[4]  = mk(1, 0, 1, 8'h00, 1, 8'h00, 8'h00, 0, 5, 3);
        tbl[5]  = mk(1, 1, 2, 8'h00, 1, 8'h01, 8'h00, 0, 5, 3);
        tbl[6]  = mk(1, 2, 3, 8'h00, 1, 8'h02, 8'h00, 1, 1, 0);
        tbl[7]  = mk(1, 3, 4, 8'h00, 1, 8'h04, 8'h00, 1, 2, 1);
        tbl[8]  = mk(0, 0, 0, 8'h00, 1, 8'h08, 8'h00, 1, 3, 2);
        tbl[9]  = mk(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 1, 4, 3);
        tbl[10] = mk(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 0, 4, 3);
        tbl[11] = mk(1, 1, 6, 8'hFD, 1, 8'h00, 8'h00, 0, 4, 3);
        tbl[12] = mk(0, 0, 0, 8'hFD, 1, 8'h02, 8'h00, 0, 4, 3);
        tbl[13] = mk(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 1, 6, 1);
        tbl[14] = mk(1, 5, 7, 8'h00, 1, 8'h00, 8'h00, 0, 6, 1);
        tbl[15] = mk(1, 0, 8, 8'h20, 0, 8'h20, 8'h00, 0, 6, 1);
        tbl[16] = mk(1, 0, 8, 8'h20, 0, 8'h20, 8'h00, 0, 6, 1);
        tbl[17] = mk(1, 0, 8, 8'h00, 1, 8'h20, 8'h00, 0, 6, 1);
        tbl[18] = mk(0, 0, 0, 8'h00, 1, 8'h01, 8'h00, 1, 7, 5);
        tbl[19] = mk(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 1, 8, 0);
        tbl[20] = mk(0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 0, 8, 0);

        #2;
        chk("ready_in_reset", vreq_ready_o, 1'b0);
        chk("req_in_reset", vec_req_o, 8'h00);
        tick();
        tick();
        rst_i = 1'b0;
        chk("force_events_reset", force_events_o, 16'd0);

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].valid, tbl[i].word, tbl[i].id, tbl[i].stall);
            #1;
            chk($sformatf("row%0d_ready", i), vreq_ready_o, tbl[i].rdy);
            chk($sformatf("row%0d_vec_req", i), vec_req_o, tbl[i].req);
            chk($sformatf("row%0d_hold", i), scalar_hold_o, tbl[i].hold);
            chk($sformatf("row%0d_issue_valid", i), issue_valid_o, tbl[i].iv);
            chk($sformatf("row%0d_issue_id", i), issue_id_o, tbl[i].iid);
            chk($sformatf("row%0d_issue_bank", i), issue_bank_o, tbl[i].ibank);
            tick();
        end

        // Starvation on bank 2: FORCE on the 4th stalled edge.
        vreq_we_i    = 1'b1;
        vreq_index_i = 5'h1A;
        vreq_way_i   = 3'd3;
        vreq_be_i    = 8'hF0;
        vreq_wdata_i = 64'hDEAD_BEEF_0123_4567;
        drive(1'b1, 3'd2, 4'd9, 8'h00);
        tick();
        drive(1'b0, 3'd0, 4'd0, 8'h04);
        #1;
        chk("held_we", vec_we_o, 1'b1);
        chk("held_index", vec_index_o, 5'h1A);
        chk("held_word", vec_word_o, 3'd2);
        chk("held_way", vec_way_o, 3'd3);
        chk("held_be", vec_be_o, 8'hF0);
        chk("held_wdata", vec_wdata_o, 64'hDEAD_BEEF_0123_4567);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("starve_no_hold_%0d", k), scalar_hold_o, 8'h00);
            chk($sformatf("starve_ready_%0d", k), vreq_ready_o, 1'b0);
        end
        tick();
        chk("starve_hold", scalar_hold_o, 8'h04);
        chk("starve_force_events", force_events_o, 16'd1);
        chk("starve_req", vec_req_o, 8'h04);

        // Broadcast keeps the bank stalled: stay in FORCE with no timeout.
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("bcast_hold_%0d", k), scalar_hold_o, 8'h04);
            chk($sformatf("bcast_force_events_%0d", k), force_events_o, 16'd1);
            chk($sformatf("bcast_issue_%0d", k), issue_valid_o, 1'b0);
        end

        vec_stall_i = 8'h00;
        #1;
        chk("release_ready", vreq_ready_o, 1'b1);
        tick();
        chk("release_issue_valid", issue_valid_o, 1'b1);
        chk("release_issue_id", issue_id_o, 4'd9);
        chk("release_issue_bank", issue_bank_o, 3'd2);
        chk("release_hold_clear", scalar_hold_o, 8'h00);
        chk("release_force_events", force_events_o, 16'd1);

        // Second starvation on bank 4, then reset while in FORCE.
        drive(1'b1, 3'd4, 4'd10, 8'h00);
        tick();
        drive(1'b0, 3'd0, 4'd0, 8'h10);
        for (int k = 0; k < 4; k++) tick();
        chk("force2_hold", scalar_hold_o, 8'h10);
        chk("force2_events", force_events_o, 16'd2);
        rst_i = 1'b1;
        #1;
        chk("rst_hold", scalar_hold_o, 8'h00);
        chk("rst_req", vec_req_o, 8'h00);
        chk("rst_events", force_events_o, 16'd0);
        chk("rst_issue", issue_valid_o, 1'b0);
        chk("rst_ready", vreq_ready_o, 1'b0);
        tick();
        rst_i = 1'b0;
        drive(1'b0, 3'd0, 4'd0, 8'h00);
        #1;
        chk("post_rst_ready", vreq_ready_o, 1'b1);
        tick();
        chk("post_rst_no_issue", issue_valid_o, 1'b0);
        chk("post_rst_issue_id", issue_id_o, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv64g_l1_vec_bank_sched.md
# rv64g_l1_vec_bank_sched

Vector-lane request scheduler in front of the per-bank 2:1 scalar/vector arbiters of the banked L1. Accepts one vector access at a time over a valid/ready handshake, steers it to the bank selected by its word offset, retries while that bank's arbiter stalls it, and counts consecutive stalls. When the count reaches a limit, it raises a per-bank scalar hold so the vector access wins, bounding vector starvation under fixed scalar priority.

## Interface
- `NUM_BANKS`, default 8: banks, word-interleaved; bank = `word[2:0]`; fixed at 8.
- `INDEX_W`, default 5: set index width.
- `ID_W`, default 4: vector request ID width.
- `STARVE_LIMIT`, default 4: consecutive stalls before forcing; legal range 1..7.
- `STAT_W`, default 16: width of the saturating force-event counter.

- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `vreq_valid_i` in 1: vector request valid.
- `vreq_ready_o` out 1: request accepted on this edge when valid & ready.
- `vreq_we_i` in 1: write.
- `vreq_index_i` in INDEX_W: set index.
- `vreq_word_i` in 3: word offset; selects the bank.
- `vreq_way_i` in 3: way.
- `vreq_be_i` in 8: byte enables.
- `vreq_wdata_i` in 64: write data.
- `vreq_id_i` in ID_W: request ID.
- `vec_req_o` in/out: out NUM_BANKS; one-hot vector request to the bank arbiters.
- `vec_we_o`, `vec_index_o`, `vec_word_o`, `vec_way_o`, `vec_be_o`, `vec_wdata_o` out: held fields, broadcast to all banks.
- `vec_stall_i` in NUM_BANKS: per-bank vector stall from the arbiters.
- `scalar_hold_o` out NUM_BANKS: one-hot request for the scalar LSU to withhold `scalar_req` to that bank.
- `issue_valid_o` out 1: one-cycle pulse; the held request was granted last cycle.
- `issue_id_o` out ID_W: ID of the granted request.
- `issue_bank_o` out 3: bank of the granted request.
- `force_events_o` out STAT_W: saturating count of entries into FORCE.

## Operation
- The holding register captures all `vreq_*` fields on the handshake.
- `bank_q` = captured `word[2:0]`.
- States:
  - IDLE: register empty.
  - PEND: request presented.
  - FORCE: request presented and `scalar_hold_o[bank_q]` asserted.
- `vec_req_o` = onehot(`bank_q`) in PEND/FORCE; all-zero in IDLE.
- grant = state ≠ IDLE & !`vec_stall_i[bank_q]`.
- `vreq_ready_o` = !`rst_i` & (state==IDLE | grant). This path is combinational through `vec_stall_i`.
- Transitions:
  - IDLE: valid & ready → PEND.
  - PEND/FORCE with grant: new handshake in the same cycle → PEND with the new request; otherwise → IDLE. Stall counter clears. The issue pulse registers for the granted request.
  - PEND with stall: counter +1. When counter+1 == STARVE_LIMIT → FORCE and `force_events_o` +1, saturating at all-ones.
  - FORCE with stall: stay; counter holds at STARVE_LIMIT.
- `scalar_hold_o` = onehot(`bank_q`) when state==FORCE, else 0. It is decoded from registered state only.
- A tag broadcast ignores the hold. Vector stalls during a broadcast are expected; the scheduler stays in FORCE and does not time out.
- Only `vec_stall_i[bank_q]` is observed. Stalls on other banks are ignored.

## Timing
- Reset values: state IDLE, counter 0, `vec_req_o`=0, `scalar_hold_o`=0, `issue_valid_o`=0, `issue_id_o`=0, `issue_bank_o`=0, `force_events_o`=0. `vreq_ready_o`=0 while `rst_i`=1.
- Handshake at edge T → `vec_req_o` valid during cycle T+1.
- No stall at T+1 → `issue_valid_o` high during T+2.
- Minimum latency from handshake to issue pulse: 2 cycles.
- Back-to-back throughput: one request per cycle.
- FORCE is entered at edge STARVE_LIMIT after presentation. The hold is visible the following cycle. The scalar LSU honours the hold combinationally, so the grant follows in that cycle unless a broadcast is in progress.
- Asserting `rst_i` mid-request drops the held request: no issue pulse, hold drops immediately (asynchronous reset).
- STARVE_LIMIT=1: FORCE is entered after the first stall.

## Structure
- Shared package `rv64g_l1_pkg`: state encoding (IDLE=2'd0, PEND=2'd1, FORCE=2'd2), `L1_NUM_BANKS`, bank-select macro.
- A separate `rv64g_l1_sat_counter` is instantiated twice (stall count, force events).
- Everything else stays flat in one module.

## Test plan
- Idle bank: `vreq_valid_i`=1, word=3, id=5, `vec_stall_i`=0 → `vec_req_o`=8'h08 at T+1; `issue_valid_o`=1, `issue_id_o`=5, `issue_bank_o`=3 at T+2.
- Stream: 4 requests on consecutive cycles, words 0..3, no stalls → `vreq_ready_o` held 1; 4 issue pulses on consecutive cycles, in order.
- Starvation: `vec_stall_i[2]` held 1 → `scalar_hold_o`=8'h04 starting the 5th cycle after presentation; `force_events_o`=1. Drop the stall → issue pulse next cycle, hold clears.
- Broadcast during FORCE: stall held 10 more cycles → state stays FORCE, hold stays asserted, `force_events_o` stays 1, no issue.
- Off-bank stall: request to bank 1 with `vec_stall_i`=8'hFD → issue with no stall counted.
- Reset in FORCE: pulse `rst_i` → all outputs 0 at once, no issue pulse; `vreq_ready_o`=1 once `rst_i` deasserts.
